// File: rtl/pipe_collision_tracker_if.sv
// Game-level signals between the box/input logic and the pipe/collision tracker.
// master drives tick/start/box_y; slave (the tracker) drives the game outputs.
interface pipe_collision_tracker_if #(
    parameter int SCORE_W = 8
);
    logic               tick;
    logic               start;
    logic [6:0]         box_y;
    logic [7:0]         pipe_x;
    logic [6:0]         gap_top;
    logic [SCORE_W-1:0] score;
    logic [1:0]         state;
    logic               game_over;
    logic [SCORE_W-1:0] high_score;

    modport master (
        output tick, start, box_y,
        input  pipe_x, gap_top, score, state, game_over, high_score
    );

    modport slave (
        input  tick, start, box_y,
        output pipe_x, gap_top, score, state, game_over, high_score
    );
endinterface

// File: rtl/pipe_collision_tracker.sv
// Scrolls one pipe, picks LFSR gap heights, detects box hits, counts score, runs IDLE/RUN/DEAD.
// All outputs registered; HIGH_SCORE_EN adds a best-score register latched on entry to DEAD.
module pipe_collision_tracker #(
    parameter int SCREEN_W = 160,
    parameter int Y_MAX    = 119,
    parameter int BOX_X    = 20,
    parameter int BOX_SIZE = 4,
    parameter int PIPE_W   = 8,
    parameter int GAP_H    = 30,
    parameter int GAP_MIN  = 10,
    parameter int SCORE_W  = 8
) (
    input  logic                     game_clk,
    input  logic                     reset,
    pipe_collision_tracker_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [7:0] PIPE_START = 8'(SCREEN_W - 1);
    localparam logic [7:0] SCORE_X    = 8'(BOX_X - PIPE_W);
    localparam logic [6:0] GAP_RESET  = 7'd40;
    localparam logic [6:0] LFSR_SEED  = 7'h5A;

    state_t             state_q;
    logic [7:0]         pipe_x_q;
    logic [6:0]         gap_top_q;
    logic [SCORE_W-1:0] score_q;
    logic               game_over_q;
    logic [6:0]         lfsr_q;

    // x^7 + x^6 + 1, shifting left with feedback into bit 0
    logic [6:0] lfsr_nxt;
    assign lfsr_nxt = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};

    logic [6:0] gap_nxt;
    assign gap_nxt = 7'(GAP_MIN) + {1'b0, lfsr_q[5:0]};

    // 9-bit operands so box_y near 127 and gap bottoms cannot wrap
    logic [8:0] by9, px9, gt9;
    logic       ceil_hit, floor_hit, h_ovl, v_miss, hit;
    assign by9 = {2'b00, bus.box_y};
    assign px9 = {1'b0, pipe_x_q};
    assign gt9 = {2'b00, gap_top_q};

    assign ceil_hit  = (by9 == 9'd0);
    assign floor_hit = (by9 + 9'(BOX_SIZE - 1)) > 9'(Y_MAX);
    assign h_ovl     = (px9 <= 9'(BOX_X + BOX_SIZE - 1)) &&
                       ((px9 + 9'(PIPE_W - 1)) >= 9'(BOX_X));
    assign v_miss    = (by9 < gt9) ||
                       ((by9 + 9'(BOX_SIZE - 1)) > (gt9 + 9'(GAP_H - 1)));
    assign hit       = ceil_hit || floor_hit || (h_ovl && v_miss);

    always_ff @(posedge game_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pipe_x_q    <= PIPE_START;
            gap_top_q   <= GAP_RESET;
            score_q     <= '0;
            game_over_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_nxt;
            case (state_q)
                IDLE: begin
                    if (bus.start) state_q <= RUN;
                end
                RUN: begin
                    // a hit freezes the field, so it also suppresses this cycle's score
                    if (hit) begin
                        state_q     <= DEAD;
                        game_over_q <= 1'b1;
                    end else if (bus.tick) begin
                        if (pipe_x_q == 8'd0) begin
                            pipe_x_q  <= PIPE_START;
                            gap_top_q <= gap_nxt;
                        end else begin
                            pipe_x_q <= pipe_x_q - 8'd1;
                        end
                        if (pipe_x_q == SCORE_X && score_q != '1)
                            score_q <= score_q + 1'b1;
                    end
                end
                DEAD: begin
                    if (bus.start) begin
                        state_q     <= IDLE;
                        pipe_x_q    <= PIPE_START;
                        gap_top_q   <= GAP_RESET;
                        score_q     <= '0;
                        game_over_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    game_over_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pipe_x    = pipe_x_q;
    assign bus.gap_top   = gap_top_q;
    assign bus.score     = score_q;
    assign bus.state     = state_q;
    assign bus.game_over = game_over_q;

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0] high_q;
    always_ff @(posedge game_clk) begin
        if (reset)
            high_q <= '0;
        else if (state_q == RUN && hit && score_q > high_q)
            high_q <= score_q;
    end
    assign bus.high_score = high_q;
`else
    assign bus.high_score = '0;
`endif
endmodule

// File: tb/tb_pipe_collision_tracker.sv
// Directed bench for pipe_collision_tracker; tracks pipe/gap/score with a small model.
module tb_pipe_collision_tracker;
    logic game_clk;
    logic reset;
    int   checks;
    int   failures;

    pipe_collision_tracker_if #(.SCORE_W(8)) bus ();

    pipe_collision_tracker dut (
        .game_clk (game_clk),
        .reset    (reset),
        .bus      (bus.slave)
    );

    initial game_clk = 1'b0;
    always #5 game_clk = ~game_clk;

    // reference LFSR, x^7 + x^6 + 1 from seed 5A
    logic [6:0] lfsr_m;
    always @(posedge game_clk) begin
        if (reset) lfsr_m <= 7'h5A;
        else       lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    end

    logic [7:0] exp_pipe;
    logic [6:0] exp_gap;
    logic [7:0] exp_score;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge game_clk);
        @(negedge game_clk);
    endtask

    task automatic model_restart();
        exp_pipe  = 8'd159;
        exp_gap   = 7'd40;
        exp_score = 8'd0;
    endtask

    task automatic run_tick();
        if (exp_pipe == 8'd0) begin
            exp_pipe = 8'd159;
            exp_gap  = 7'd10 + {1'b0, lfsr_m[5:0]};
        end else begin
            if (exp_pipe == 8'd12 && exp_score != 8'hFF) exp_score++;
            exp_pipe--;
        end
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
    endtask

    task automatic run_until_pipe(input logic [7:0] target);
        for (int i = 0; i < 2000 && exp_pipe != target; i++) run_tick();
        chk("reach_pipe", {24'd0, bus.pipe_x}, {24'd0, target});
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset     = 1'b1;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.box_y = 7'd60;
        model_restart();
        @(negedge game_clk);
        cycle();
        cycle();
        reset = 1'b0;

        chk("rst_state", {30'd0, bus.state}, 32'd0);
        chk("rst_pipe", {24'd0, bus.pipe_x}, 32'd159);
        chk("rst_gap", {25'd0, bus.gap_top}, 32'd40);
        chk("rst_score", {24'd0, bus.score}, 32'd0);
        chk("rst_go", {31'd0, bus.game_over}, 32'd0);
        chk("rst_high", {24'd0, bus.high_score}, 32'd0);

        // ticks in IDLE, and in the start cycle, are ignored
        bus.tick = 1'b1;
        cycle(); cycle(); cycle();
        chk("idle_hold_pipe", {24'd0, bus.pipe_x}, 32'd159);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        chk("start_run", {30'd0, bus.state}, 32'd1);
        chk("start_tick_ignored", {24'd0, bus.pipe_x}, 32'd159);

        for (int i = 0; i < 10; i++) run_tick();
        chk("t1_pipe", {24'd0, bus.pipe_x}, 32'd149);
        chk("t1_score", {24'd0, bus.score}, 32'd0);
        chk("t1_go", {31'd0, bus.game_over}, 32'd0);

        // pass the pipe with the box inside the gap
        bus.box_y = 7'd50;
        run_until_pipe(8'd12);
        chk("t3_alive", {30'd0, bus.state}, 32'd1);
        chk("t3_score0", {24'd0, bus.score}, 32'd0);
        run_tick();
        chk("t3_score1", {24'd0, bus.score}, 32'd1);
        chk("t3_pipe11", {24'd0, bus.pipe_x}, 32'd11);

        bus.box_y = 7'd60;
        run_until_pipe(8'd0);
        run_tick();
        chk("t2_respawn", {24'd0, bus.pipe_x}, 32'd159);
        chk("t2_gap", {25'd0, bus.gap_top}, {25'd0, exp_gap});

        // floor hit through wrapped box_y
        bus.box_y = 7'd127;
        cycle();
        chk("floor_dead", {30'd0, bus.state}, 32'd2);
        chk("floor_go", {31'd0, bus.game_over}, 32'd1);
        chk("floor_score", {24'd0, bus.score}, 32'd1);
`ifdef HIGH_SCORE_EN
        chk("floor_high", {24'd0, bus.high_score}, 32'd1);
`else
        chk("floor_high", {24'd0, bus.high_score}, 32'd0);
`endif
        bus.tick = 1'b1;
        cycle();
        bus.tick = 1'b0;
        chk("dead_hold_pipe", {24'd0, bus.pipe_x}, 32'd159);
        pulse_start();
        model_restart();
        chk("restart_idle", {30'd0, bus.state}, 32'd0);
        chk("restart_score", {24'd0, bus.score}, 32'd0);
        chk("restart_pipe", {24'd0, bus.pipe_x}, 32'd159);
        chk("restart_gap", {25'd0, bus.gap_top}, 32'd40);
        chk("restart_go", {31'd0, bus.game_over}, 32'd0);

        // ceiling hit
        bus.box_y = 7'd60;
        pulse_start();
        chk("ceil_run", {30'd0, bus.state}, 32'd1);
        bus.box_y = 7'd0;
        cycle();
        chk("ceil_dead", {30'd0, bus.state}, 32'd2);
        pulse_start();
        model_restart();
        chk("ceil_restart", {30'd0, bus.state}, 32'd0);

        // box above the gap dies as the pipe reaches its right edge
        bus.box_y = 7'd20;
        pulse_start();
        run_until_pipe(8'd23);
        chk("t4_alive_at23", {30'd0, bus.state}, 32'd1);
        run_tick();
        chk("t4_dead", {30'd0, bus.state}, 32'd2);
        chk("t4_go", {31'd0, bus.game_over}, 32'd1);
        chk("t4_frozen", {24'd0, bus.pipe_x}, 32'd23);

        // reset mid-scroll beats start and tick
        pulse_start();
        model_restart();
        bus.box_y = 7'd60;
        pulse_start();
        for (int i = 0; i < 30; i++) run_tick();
        chk("mid_pipe", {24'd0, bus.pipe_x}, 32'd129);
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        cycle();
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        model_restart();
        chk("mid_rst_state", {30'd0, bus.state}, 32'd0);
        chk("mid_rst_pipe", {24'd0, bus.pipe_x}, 32'd159);

`ifdef HIGH_SCORE_EN
        pulse_start();
        for (int i = 0; i < 2000 && exp_score < 8'd3; i++) begin
            bus.box_y = exp_gap + 7'd5;
            run_tick();
        end
        chk("hs_score3", {24'd0, bus.score}, 32'd3);
        bus.box_y = 7'd127;
        cycle();
        chk("hs_high3", {24'd0, bus.high_score}, 32'd3);
        pulse_start();
        model_restart();
        pulse_start();
        bus.box_y = 7'd45;
        for (int i = 0; i < 2000 && exp_score < 8'd1; i++) run_tick();
        bus.box_y = 7'd127;
        cycle();
        chk("hs_score1", {24'd0, bus.score}, 32'd1);
        chk("hs_keep3", {24'd0, bus.high_score}, 32'd3);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("hs_reset", {24'd0, bus.high_score}, 32'd0);
`else
        chk("hs_tied0", {24'd0, bus.high_score}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipe_collision_tracker.md
Name: pipe_collision_tracker

Overview:
Downstream consumer of the box y-coordinate. Scrolls a single pipe obstacle leftward on each game tick and picks a pseudo-random gap height for each new pipe. Checks the box against the pipe, floor and ceiling, and counts the pipes passed. Runs the game-level IDLE/RUN/DEAD state machine that the display and score logic read.

Parameters:
SCREEN_W, 160, screen width in pixels; the pipe respawns at SCREEN_W-1.
Y_MAX, 119, lowest visible row; any box pixel beyond it is a floor hit.
BOX_X, 20, fixed left column of the box.
BOX_SIZE, 4, box width and height in pixels.
PIPE_W, 8, pipe width in pixels.
GAP_H, 30, height of the pipe gap in rows.
GAP_MIN, 10, minimum gap_top value.
SCORE_W, 8, width of the score counter.

Ports:
game_clk  in  1  game clock; all state updates on its posedge.
reset  in  1  synchronous, active-high reset.
tick  in  1  scroll enable, one game_clk cycle wide.
start  in  1  start/restart request, level sampled on every game_clk.
box_y  in  7  current box top row from the box register.
pipe_x  out  8  pipe left column.
gap_top  out  7  first row of the gap.
score  out  SCORE_W  number of pipes passed.
state  out  2  current state: 0=IDLE, 1=RUN, 2=DEAD.
game_over  out  1  high while in DEAD.
high_score  out  SCORE_W  best score (see Optional Feature).

Behaviour:
- All outputs are registered; no output is a combinational path from an input.
- Reset values: state=IDLE, pipe_x=SCREEN_W-1, gap_top=40, score=0, game_over=0, high_score=0, lfsr=7'h5A.
- LFSR: 7-bit, polynomial x^7+x^6+1. Advances every game_clk in every state; only reset reloads it. Start timing therefore seeds the gap sequence.
- IDLE:
  - All game state is held.
  - start=1 -> RUN on the next edge.
  - tick is ignored, including in the same cycle as start.
- RUN, on tick=1:
  - pipe_x != 0: pipe_x decrements by 1.
  - pipe_x == 0: pipe_x <= SCREEN_W-1 and gap_top <= GAP_MIN + lfsr[5:0], giving a range of 10..73.
  - pipe_x == BOX_X-PIPE_W (12): score increments, saturating at all-ones. The pipe is then fully past the box.
- RUN, collision check: evaluated on every game_clk, whether or not tick is high. Comparisons use 9-bit arithmetic so nothing wraps. A hit is any of:
  - box_y == 0 (ceiling).
  - box_y + BOX_SIZE - 1 > Y_MAX (floor). This includes box_y wrapping to 127.
  - Horizontal overlap with the pipe AND a vertical miss of the gap:
    - horizontal overlap: pipe_x <= BOX_X+BOX_SIZE-1 and pipe_x+PIPE_W-1 >= BOX_X.
    - vertical miss: box_y < gap_top or box_y+BOX_SIZE-1 > gap_top+GAP_H-1.
- On a hit:
  - state <= DEAD and game_over <= 1 on the same edge.
  - pipe_x, gap_top and score freeze from that edge on.
  - If a hit and a score increment fall in the same cycle, the hit wins and score is not incremented.
- DEAD:
  - All game state is held; game_over=1.
  - start=1 -> IDLE on the next edge, with pipe_x=SCREEN_W-1, gap_top=40, score=0, game_over=0.
  - lfsr and high_score are not affected by restart.
- reset asserted in any state, mid-scroll included, forces the reset values on the next edge. Reset has priority over start, tick and collision.
- Encoding 3 for state is unreachable; if ever entered, the block returns to IDLE on the next edge.

Optional Feature:
Macro HIGH_SCORE_EN.
- Defined: on the edge that enters DEAD, high_score <= score if score > high_score. high_score is cleared only by reset.
- Not defined: high_score is tied to 0 and no comparator or register is built.

Test Plan:
1. Reset, then start=1 for 1 cycle, then 10 ticks with box_y=60 -> state=RUN, pipe_x=149, score=0, game_over=0.
2. Run until pipe_x=0, box_y=60, then 1 tick -> pipe_x=159, gap_top equals 10 + lfsr[5:0] as predicted by a bench LFSR model.
3. gap_top=40, box_y=50, tick at pipe_x=12 -> score 0->1, no hit while pipe_x passes 23..12.
4. gap_top=40, box_y=20, pipe_x reaches 23 -> DEAD on the next edge, game_over=1, pipe_x frozen at 23.
5. In RUN, drive box_y=127 (wrap) and, separately, box_y=0 -> DEAD on the next edge. Then start=1 -> IDLE, score=0, pipe_x=159.
6. With HIGH_SCORE_EN: score 3 then die -> high_score=3. Restart, score 1 then die -> high_score stays 3. reset -> high_score=0.
